// File: rtl/net_sched_pkg.sv
// Shared types and width helpers for the network output-port scheduler.
package net_sched_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_e;

    // Counter width able to hold every value 0..max_val inclusive.
    function automatic int cnt_nbits(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_en.sv
// Round-robin arbiter whose priority pointer moves only when en is asserted;
// the pointer then points just past the current winner.
module rr_arb_en
    import net_sched_pkg::*;
#(
    parameter int p_num_reqs = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [p_num_reqs-1:0] reqs,
    output logic [p_num_reqs-1:0] grants
);

    localparam int c_idx_nbits = idx_nbits(p_num_reqs);
    localparam logic [p_num_reqs-1:0] c_one = p_num_reqs'(1);

    logic [c_idx_nbits-1:0] ptr_r;
    logic [p_num_reqs-1:0]  mask_s;
    logic [p_num_reqs-1:0]  hi_reqs_s;
    logic [p_num_reqs-1:0]  pick_s;
    logic [c_idx_nbits-1:0] grant_idx_s;

    // Prefer requesters at or above the pointer; otherwise wrap to the lowest one.
    always_comb begin
        mask_s      = ~((c_one << ptr_r) - c_one);
        hi_reqs_s   = reqs & mask_s;
        pick_s      = (hi_reqs_s != '0) ? hi_reqs_s : reqs;
        grants      = pick_s & (~pick_s + c_one);
        grant_idx_s = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            grant_idx_s = grant_idx_s | ({c_idx_nbits{grants[i]}} & c_idx_nbits'(i));
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (en) begin
            if (grant_idx_s == c_idx_nbits'(p_num_reqs - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_idx_s + c_idx_nbits'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/net_out_port_sched.sv
// Packet-granular, credit-controlled scheduler of several input-queue heads
// onto one output link; a granted requester keeps the link until its last flit.
module net_out_port_sched
    import net_sched_pkg::*;
#(
    parameter int p_num_reqs    = 4,
    parameter int p_msg_nbits   = 44,
    parameter int p_num_credits = 4,
    parameter int c_cnt_nbits   = cnt_nbits(p_num_credits)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] req_msg,
    input  logic [p_num_reqs-1:0]             req_last,
    output logic                              out_val,
    output logic [p_msg_nbits-1:0]            out_msg,
    input  logic                              credit_ret,
    output logic [c_cnt_nbits-1:0]            credits
);

    localparam int c_idx_nbits = idx_nbits(p_num_reqs);
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_credits);
    localparam logic [p_num_reqs-1:0]  c_one  = p_num_reqs'(1);

    sched_state_e           state_r;
    sched_state_e           state_n_s;
    logic [c_idx_nbits-1:0] owner_r;
    logic [c_idx_nbits-1:0] owner_n_s;
    logic [c_cnt_nbits-1:0] credits_r;
    logic                   credit_ovf_r;

    logic [p_num_reqs-1:0]  eligible_s;
    logic [p_num_reqs-1:0]  grant_s;
    logic [c_idx_nbits-1:0] grant_idx_s;
    logic                   fire_s;
    logic                   last_s;
    logic                   pkt_done_s;
    logic                   ovf_s;

    // While locked only the owner may compete, so the arbiter cannot switch mid-packet.
    always_comb begin
        if (state_r == ST_LOCKED) begin
            eligible_s = req_val & (c_one << owner_r);
        end else begin
            eligible_s = req_val;
        end
    end

    rr_arb_en #(
        .p_num_reqs (p_num_reqs)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (pkt_done_s),
        .reqs   (eligible_s),
        .grants (grant_s)
    );

    // Handshake, AND-OR output mux and grant index; all gated off by reset or no credit.
    always_comb begin
        if (!reset && (credits_r != '0)) begin
            req_rdy = grant_s;
        end else begin
            req_rdy = '0;
        end
        fire_s      = |req_rdy;
        last_s      = |(req_rdy & req_last);
        pkt_done_s  = fire_s && last_s;
        out_val     = fire_s;
        out_msg     = '0;
        grant_idx_s = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            out_msg     = out_msg | ({p_msg_nbits{req_rdy[i]}} & req_msg[i*p_msg_nbits +: p_msg_nbits]);
            grant_idx_s = grant_idx_s | ({c_idx_nbits{grant_s[i]}} & c_idx_nbits'(i));
        end
        ovf_s = credit_ret && !fire_s && (credits_r == c_full);
    end

    // Next-state logic: lock on a non-last flit, release on the owner's last flit.
    always_comb begin
        state_n_s = state_r;
        owner_n_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s && !last_s) begin
                    state_n_s = ST_LOCKED;
                    owner_n_s = grant_idx_s;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (pkt_done_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_LOCKED;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, owner, credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            credits_r    <= c_full;
            credit_ovf_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            owner_r      <= owner_n_s;
            credit_ovf_r <= credit_ovf_r | ovf_s;
            case ({fire_s, credit_ret})
                2'b10:   credits_r <= credits_r - c_cnt_nbits'(1);
                2'b01:   credits_r <= ovf_s ? credits_r : credits_r + c_cnt_nbits'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    assign credits = credits_r;

endmodule

// File: tb/tb_net_out_port_sched.sv
// Directed bench for net_out_port_sched: reset, round-robin, packet lock,
// credit exhaustion/return, overflow saturation and reset mid-packet.
module tb_net_out_port_sched;

    localparam int N  = 4;
    localparam int W  = 44;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_val;
    logic [N-1:0]   req_rdy;
    logic [N*W-1:0] req_msg;
    logic [N-1:0]   req_last;
    logic           out_val;
    logic [W-1:0]   out_msg;
    logic           credit_ret;
    logic [CW-1:0]  credits;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] msg_c [N];

    always #5 clk = ~clk;

    net_out_port_sched #(
        .p_num_reqs    (N),
        .p_msg_nbits   (W),
        .p_num_credits (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_msg    (req_msg),
        .req_last   (req_last),
        .out_val    (out_val),
        .out_msg    (out_msg),
        .credit_ret (credit_ret),
        .credits    (credits)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            msg_c[i] = 44'hABC_0000_0000 + 44'(i + 1);
            req_msg[i*W +: W] = msg_c[i];
        end

        // T1 reset with everything requesting
        reset = 1'b1; req_val = 4'b1111; req_last = 4'b1111; credit_ret = 1'b0;
        settle();
        check("t1_rdy_in_reset", 64'(req_rdy), 64'h0);
        check("t1_val_in_reset", 64'(out_val), 64'h0);
        check("t1_msg_in_reset", 64'(out_msg), 64'h0);
        tick();
        check("t1_rdy_in_reset2", 64'(req_rdy), 64'h0);
        tick();
        reset = 1'b0; credit_ret = 1'b1;
        settle();
        check("t1_credits_after", 64'(credits), 64'd4);
        check("t1_req0_first", 64'(req_rdy), 64'b0001);

        // T2 round robin of single-flit packets, credits returned every cycle
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_grant%0d", k), 64'(req_rdy), 64'(4'b0001 << (k % 4)));
            check($sformatf("t2_msg%0d", k), 64'(out_msg), 64'(msg_c[k % 4]));
            check($sformatf("t2_credits%0d", k), 64'(credits), 64'd4);
            tick();
        end

        // T3 req1 sends a 3-flit packet with a bubble; req2 waits throughout
        req_val = 4'b0110; req_last = 4'b0100; credit_ret = 1'b1;
        settle();
        check("t3_flit1", 64'(req_rdy), 64'b0010);
        tick();
        req_val = 4'b0100; credit_ret = 1'b0;
        settle();
        check("t3_bubble_rdy", 64'(req_rdy), 64'b0000);
        check("t3_bubble_val", 64'(out_val), 64'h0);
        tick();
        req_val = 4'b0110; credit_ret = 1'b1;
        settle();
        check("t3_flit2", 64'(req_rdy), 64'b0010);
        tick();
        req_last = 4'b0110;
        settle();
        check("t3_flit3", 64'(req_rdy), 64'b0010);
        tick();
        settle();
        check("t3_req2_after", 64'(req_rdy), 64'b0100);
        check("t3_req2_msg", 64'(out_msg), 64'(msg_c[2]));
        tick();

        // T4 credit exhaustion on req0
        req_val = 4'b0001; req_last = 4'b1111; credit_ret = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("t4_fire%0d", k), 64'(out_val), 64'h1);
            check($sformatf("t4_credits%0d", k), 64'(credits), 64'(4 - k));
            tick();
        end
        check("t4_stall_val", 64'(out_val), 64'h0);
        check("t4_stall_rdy", 64'(req_rdy), 64'h0);
        credit_ret = 1'b1;
        settle();
        check("t4_ret_same_cycle", 64'(out_val), 64'h0);
        tick();
        credit_ret = 1'b0;
        settle();
        check("t4_one_more_fire", 64'(out_val), 64'h1);
        check("t4_one_credit", 64'(credits), 64'd1);
        tick();
        check("t4_stall_again", 64'(out_val), 64'h0);
        check("t4_zero_credits", 64'(credits), 64'd0);

        // T5 simultaneous fire and return at credits=1, then overflow
        req_val = 4'b0000; credit_ret = 1'b1;
        tick();
        req_val = 4'b0001;
        settle();
        check("t5_fire_at_1", 64'(out_val), 64'h1);
        check("t5_credits_1", 64'(credits), 64'd1);
        tick();
        check("t5_credits_hold", 64'(credits), 64'd1);
        check("t5_next_fire", 64'(out_val), 64'h1);
        tick();
        req_val = 4'b0000;
        tick(); tick(); tick();
        check("t5_full", 64'(credits), 64'd4);
        check("t5_no_ovf_yet", 64'(dut.credit_ovf_r), 64'h0);
        tick();
        check("t5_saturate", 64'(credits), 64'd4);
        check("t5_ovf_flag", 64'(dut.credit_ovf_r), 64'h1);
        credit_ret = 1'b0;

        // T6 reset while req3 holds the link
        req_val = 4'b1000; req_last = 4'b0000;
        settle();
        check("t6_req3_grant", 64'(req_rdy), 64'b1000);
        tick();
        req_val = 4'b1001;
        settle();
        check("t6_locked_req3", 64'(req_rdy), 64'b1000);
        reset = 1'b1;
        settle();
        check("t6_rdy_in_reset", 64'(req_rdy), 64'h0);
        tick();
        reset = 1'b0;
        settle();
        check("t6_req0_first", 64'(req_rdy), 64'b0001);
        check("t6_state_idle", 64'(dut.state_r), 64'h0);
        check("t6_credits", 64'(credits), 64'd4);
        check("t6_ovf_cleared", 64'(dut.credit_ovf_r), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
